pc_ctrl_unit: RTL and testbench
===============================

PC_CTRL_UNIT -- requirements
Module: pc_ctrl_unit

Interface
REQ-001 Parameter PC_W, 16, program-counter and target width in bits.
REQ-002 Parameter INSTR_BYTES, 2, instruction size in bytes; power of two; branch offsets are scaled by it.
REQ-003 Parameter RESET_VEC, 0, PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2; used only when PC_CTRL_UNIT_RAS_EN is defined.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pc  out  PC_W  current fetch address.
REQ-008 pc_valid  out  1  high when pc is a valid fetch address for this cycle.
REQ-009 link_addr  out  PC_W  pc + INSTR_BYTES, combinational, for the BL link write.
REQ-010 state  out  2  FSM state: 00 BOOT, 01 RUN, 10 HALT.
REQ-011 signext  in  PC_W  sign-extended branch offset, counted in instructions.
REQ-012 branch  in  1  conditional branch; taken when alu_zero=1.
REQ-013 alu_zero  in  1  ALU zero flag.
REQ-014 uncondbranch  in  1  unconditional PC-relative branch.
REQ-015 link  in  1  qualifies uncondbranch as BL (call).
REQ-016 brreg  in  1  register-indirect branch (BR/RET).
REQ-017 ret  in  1  qualifies brreg as a return.
REQ-018 regtarget  in  PC_W  register-supplied target for brreg.
REQ-019 stall  in  1  hold pc; no state update.
REQ-020 halt  in  1  request HALT.
REQ-021 resume  in  1  leave HALT.

Function
REQ-022 The unit SHALL use a 3-state FSM: BOOT→RUN unconditionally after one cycle; RUN→HALT when halt=1 and stall=0; HALT→RUN when resume=1.
REQ-023 pc_valid SHALL be 1 only in RUN.
REQ-024 In BOOT and HALT, pc SHALL hold its value; branch, stall and RAS inputs SHALL be ignored.
REQ-025 In RUN with stall=1, pc, FSM state and RAS SHALL hold; halt SHALL be ignored.
REQ-026 In RUN with stall=0, next pc SHALL be chosen by priority: brreg → target; branch&alu_zero → pc+signext*INSTR_BYTES; uncondbranch → pc+signext*INSTR_BYTES; otherwise pc+INSTR_BYTES.
REQ-027 The brreg target SHALL be regtarget, or the RAS top per REQ-034.
REQ-028 branch=1 with alu_zero=0 SHALL fall through to lower priorities; when uncondbranch is also 1, the branch SHALL take the uncondbranch target.
REQ-029 All pc arithmetic SHALL be modulo 2^PC_W (wrap-around); signext*INSTR_BYTES SHALL be a left shift by log2(INSTR_BYTES), with bits beyond PC_W discarded.
REQ-030 The unit SHALL force regtarget low-order bits below log2(INSTR_BYTES) to zero.
REQ-031 A RUN cycle with halt=1 and stall=0 SHALL still apply that cycle's pc update before entering HALT.
REQ-032 Latency: pc SHALL show the selected target one cycle after the deciding inputs; no bubble.

Reset
REQ-033 On reset=1 at a clock edge, regardless of state or other inputs: pc=RESET_VEC, state=BOOT, pc_valid=0, RAS pointer and count=0; reset mid-branch or mid-HALT SHALL behave identically.

Configuration
REQ-034 With PC_CTRL_UNIT_RAS_EN defined: a RAS_DEPTH return-address stack SHALL push link_addr on an accepted uncondbranch&link; an accepted brreg&ret with count>0 SHALL target and pop the top entry (regtarget ignored). On push when full, the oldest entry SHALL be overwritten (circular) with count saturating. brreg&ret with count=0 SHALL use regtarget.
REQ-035 Without PC_CTRL_UNIT_RAS_EN: no stack storage; ret and link SHALL have no effect beyond REQ-026; brreg always targets regtarget.

Verification
REQ-036 Reset, then idle for 3 cycles -> pc=0/pc_valid=0 in the 1st cycle, then pc=0,2,4 with pc_valid=1.
REQ-037 pc=0x0010, branch=1, alu_zero=1, signext=0xFFFC -> pc=0x0008; same with alu_zero=0 -> pc=0x0012.
REQ-038 pc=0xFFFE, sequential step -> pc=0x0000; stall=1 for 2 cycles -> pc constant, then resumes.
REQ-039 halt=1 at pc=0x0020 -> pc=0x0022, state=HALT, pc_valid=0; held for 5 cycles; resume=1 -> RUN, pc=0x0024 next.
REQ-040 RAS_EN, RAS_DEPTH=4: BL at 0x0100, 0x0200 then RET,RET with regtarget=0x0000 -> pc=0x0202, then 0x0102; a 3rd RET -> 0x0000.
REQ-041 reset asserted in HALT with branch=1 -> pc=RESET_VEC, state=BOOT, RAS empty.

Source files
------------

// File: rtl/pc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pc_ctrl_unit
//   Program-counter control: a BOOT/RUN/HALT sequencer that selects the next
//   fetch address from register-indirect, conditional and unconditional
//   PC-relative branches, or a sequential step.
//   Optional return-address stack: define PC_CTRL_UNIT_RAS_EN to enable it.
//
// Parameters
//   PC_W        program-counter / target width in bits
//   INSTR_BYTES instruction size in bytes (power of two); scales offsets
//   RESET_VEC   pc value loaded on reset
//   RAS_DEPTH   return-address-stack entries (power of two, >= 2)
//
// Ports
//   i_clock        sole clock, rising edge
//   i_reset        synchronous active-high reset
//   o_pc           current fetch address
//   o_pc_valid     o_pc is a valid fetch address (RUN only)
//   o_link_addr    o_pc + INSTR_BYTES (combinational), BL link value
//   o_state        00 BOOT, 01 RUN, 10 HALT
//   i_signext      sign-extended branch offset in instructions
//   i_branch       conditional branch, taken when i_alu_zero=1
//   i_alu_zero     ALU zero flag
//   i_uncondbranch unconditional PC-relative branch
//   i_link         qualifies i_uncondbranch as a call
//   i_brreg        register-indirect branch
//   i_ret          qualifies i_brreg as a return
//   i_regtarget    register-supplied target for i_brreg
//   i_stall        hold pc and all state
//   i_halt         request HALT
//   i_resume       leave HALT
// ---------------------------------------------------------------------------
module pc_ctrl_unit #(
    parameter int              PC_W        = 16,
    parameter int              INSTR_BYTES = 2,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            i_clock,
    input  logic            i_reset,
    output logic [PC_W-1:0] o_pc,
    output logic            o_pc_valid,
    output logic [PC_W-1:0] o_link_addr,
    output logic [1:0]      o_state,
    input  logic [PC_W-1:0] i_signext,
    input  logic            i_branch,
    input  logic            i_alu_zero,
    input  logic            i_uncondbranch,
    input  logic            i_link,
    input  logic            i_brreg,
    input  logic            i_ret,
    input  logic [PC_W-1:0] i_regtarget,
    input  logic            i_stall,
    input  logic            i_halt,
    input  logic            i_resume
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam int              SHIFT      = $clog2(INSTR_BYTES);
    localparam logic [PC_W-1:0] STEP       = PC_W'(INSTR_BYTES);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(INSTR_BYTES - 1));

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_pc_valid;

    logic [PC_W-1:0] w_link_addr;
    logic [PC_W-1:0] w_rel_target;
    logic [PC_W-1:0] w_reg_target;
    logic [PC_W-1:0] w_brreg_target;
    logic [PC_W-1:0] w_next_pc;

    assign w_link_addr  = r_pc + STEP;
    // Shift stays at PC_W width, so offset bits beyond the PC are dropped.
    assign w_rel_target = r_pc + (i_signext << SHIFT);
    assign w_reg_target = i_regtarget & ALIGN_MASK;

`ifdef PC_CTRL_UNIT_RAS_EN
    localparam int             PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);

    logic [PC_W-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ras_ptr;   // next write slot; top is r_ras_ptr-1
    logic [PTR_W:0]   r_ras_cnt;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_pop;
    logic             w_push;

    assign w_top_idx = r_ras_ptr - PTR_W'(1);
    assign w_pop     = i_brreg && i_ret && (r_ras_cnt != '0);
    // brreg wins the pc priority, so a coincident call is not accepted.
    assign w_push    = !i_brreg && i_uncondbranch && i_link;
    assign w_brreg_target = w_pop ? r_ras[w_top_idx] : w_reg_target;
`else
    logic w_unused;
    assign w_unused       = ^{i_ret, i_link, 1'(RAS_DEPTH)};
    assign w_brreg_target = w_reg_target;
`endif

    always_comb begin
        w_next_pc = w_link_addr;
        if (i_brreg)
            w_next_pc = w_brreg_target;
        else if ((i_branch && i_alu_zero) || i_uncondbranch)
            w_next_pc = w_rel_target;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc       <= RESET_VEC;
            r_state    <= ST_BOOT;
            r_pc_valid <= 1'b0;
`ifdef PC_CTRL_UNIT_RAS_EN
            r_ras_ptr  <= '0;
            r_ras_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_RUN;
                    r_pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (!i_stall) begin
                        r_pc <= w_next_pc;
                        if (i_halt) begin
                            r_state    <= ST_HALT;
                            r_pc_valid <= 1'b0;
                        end
`ifdef PC_CTRL_UNIT_RAS_EN
                        if (w_pop) begin
                            r_ras_ptr <= w_top_idx;
                            r_ras_cnt <= r_ras_cnt - (PTR_W + 1)'(1);
                        end else if (w_push) begin
                            // Circular: when full this overwrites the oldest entry.
                            r_ras[r_ras_ptr] <= w_link_addr;
                            r_ras_ptr        <= r_ras_ptr + PTR_W'(1);
                            if (r_ras_cnt != RAS_FULL)
                                r_ras_cnt <= r_ras_cnt + (PTR_W + 1)'(1);
                        end
`endif
                    end
                end
                ST_HALT: begin
                    if (i_resume) begin
                        r_state    <= ST_RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc        = r_pc;
    assign o_pc_valid  = r_pc_valid;
    assign o_link_addr = w_link_addr;
    assign o_state     = r_state;

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_ctrl_unit
//   Self-checking bench for pc_ctrl_unit: a vector table, hand-written call /
//   return and reset-in-HALT sequences, then randomized stimulus compared
//   against a queue-based reference model. Honours PC_CTRL_UNIT_RAS_EN.
// ---------------------------------------------------------------------------
module tb_pc_ctrl_unit;

    localparam int PC_W        = 16;
    localparam int INSTR_BYTES = 2;
    localparam int RAS_DEPTH   = 4;
`ifdef PC_CTRL_UNIT_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    localparam int F_RST = 1,   F_BR  = 2,   F_Z   = 4,   F_UNC = 8;
    localparam int F_LNK = 16,  F_BRR = 32,  F_RET = 64,  F_STL = 128;
    localparam int F_HLT = 256, F_RES = 512;

    localparam logic [1:0] S_BOOT = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10;

    logic            clk;
    logic            rst;
    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic [PC_W-1:0] link_addr;
    logic [1:0]      state;
    logic [PC_W-1:0] signext;
    logic            branch, alu_zero, uncondbranch, link, brreg, ret;
    logic [PC_W-1:0] regtarget;
    logic            stall, halt, resume;

    int checks   = 0;
    int failures = 0;

    pc_ctrl_unit #(
        .PC_W       (PC_W),
        .INSTR_BYTES(INSTR_BYTES),
        .RESET_VEC  (16'h0000),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .o_pc          (pc),
        .o_pc_valid    (pc_valid),
        .o_link_addr   (link_addr),
        .o_state       (state),
        .i_signext     (signext),
        .i_branch      (branch),
        .i_alu_zero    (alu_zero),
        .i_uncondbranch(uncondbranch),
        .i_link        (link),
        .i_brreg       (brreg),
        .i_ret         (ret),
        .i_regtarget   (regtarget),
        .i_stall       (stall),
        .i_halt        (halt),
        .i_resume      (resume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          flags;
        logic [15:0] se;
        logic [15:0] rt;
        logic [15:0] epc;
        logic [1:0]  est;
        logic        ev;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int f, input logic [15:0] se, input logic [15:0] rt,
                                input logic [15:0] epc, input logic [1:0] est, input logic ev);
        vec_t v;
        v.flags = f; v.se = se; v.rt = rt; v.epc = epc; v.est = est; v.ev = ev;
        return v;
    endfunction

    task automatic drive(input int f, input logic [15:0] se, input logic [15:0] rt);
        rst          = (f & F_RST) != 0;
        branch       = (f & F_BR)  != 0;
        alu_zero     = (f & F_Z)   != 0;
        uncondbranch = (f & F_UNC) != 0;
        link         = (f & F_LNK) != 0;
        brreg        = (f & F_BRR) != 0;
        ret          = (f & F_RET) != 0;
        stall        = (f & F_STL) != 0;
        halt         = (f & F_HLT) != 0;
        resume       = (f & F_RES) != 0;
        signext      = se;
        regtarget    = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] epc, input logic [1:0] est,
                           input logic ev);
        chk({tag, ".pc"},    32'(pc),        32'(epc));
        chk({tag, ".state"}, 32'(state),     32'(est));
        chk({tag, ".valid"}, 32'(pc_valid),  32'(ev));
        chk({tag, ".link"},  32'(link_addr), 32'(16'(epc + 16'd2)));
    endtask

    // Reference model: architectural rules only, stack as a bounded queue.
    int m_pc;
    int m_st;   // 0 BOOT, 1 RUN, 2 HALT
    int m_stack[$];

    task automatic model_step();
        int t;
        if (rst) begin
            m_pc = 0;
            m_st = 0;
            m_stack.delete();
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 2) begin
            if (resume) m_st = 1;
        end else if (!stall) begin
            if (brreg) begin
                if (RAS_ON && ret && m_stack.size() > 0)
                    t = m_stack.pop_back();
                else
                    t = int'(regtarget) & ~(INSTR_BYTES - 1);
            end else if ((branch && alu_zero) || uncondbranch) begin
                t = m_pc + int'(signext) * INSTR_BYTES;
            end else begin
                t = m_pc + INSTR_BYTES;
            end
            if (RAS_ON && !brreg && uncondbranch && link) begin
                if (m_stack.size() == RAS_DEPTH) void'(m_stack.pop_front());
                m_stack.push_back((m_pc + INSTR_BYTES) & 'hFFFF);
            end
            m_pc = t & 'hFFFF;
            if (halt) m_st = 2;
        end
    endtask

    initial begin
        drive(0, 16'h0, 16'h0);

        // Sequential table: each row's expectation is the state after its edge.
        tbl.push_back(mk(F_RST,                 16'h0000, 16'h0000, 16'h0000, S_BOOT, 1'b0));
        tbl.push_back(mk(0,                     16'h0000, 16'h0000, 16'h0000, S_RUN,  1'b1));
        tbl.push_back(mk(0,                     16'h0000, 16'h0000, 16'h0002, S_RUN,  1'b1));
        tbl.push_back(mk(0,                     16'h0000, 16'h0000, 16'h0004, S_RUN,  1'b1));
        tbl.push_back(mk(F_BRR,                 16'h0000, 16'h0011, 16'h0010, S_RUN,  1'b1));
        tbl.push_back(mk(F_BR | F_Z,            16'hFFFC, 16'h0000, 16'h0008, S_RUN,  1'b1));
        tbl.push_back(mk(F_UNC,                 16'h0004, 16'h0000, 16'h0010, S_RUN,  1'b1));
        tbl.push_back(mk(F_BR,                  16'hFFFC, 16'h0000, 16'h0012, S_RUN,  1'b1));
        tbl.push_back(mk(F_BR | F_UNC,          16'h0002, 16'h0000, 16'h0016, S_RUN,  1'b1));
        tbl.push_back(mk(F_BRR | F_BR | F_Z,    16'h0004, 16'hFFFE, 16'hFFFE, S_RUN,  1'b1));
        tbl.push_back(mk(0,                     16'h0000, 16'h0000, 16'h0000, S_RUN,  1'b1));
        tbl.push_back(mk(F_STL | F_BRR,         16'h0000, 16'h0080, 16'h0000, S_RUN,  1'b1));
        tbl.push_back(mk(F_STL | F_HLT,         16'h0000, 16'h0000, 16'h0000, S_RUN,  1'b1));
        tbl.push_back(mk(0,                     16'h0000, 16'h0000, 16'h0002, S_RUN,  1'b1));
        tbl.push_back(mk(F_BRR,                 16'h0000, 16'h0020, 16'h0020, S_RUN,  1'b1));
        tbl.push_back(mk(F_HLT,                 16'h0000, 16'h0000, 16'h0022, S_HALT, 1'b0));
        tbl.push_back(mk(F_BR | F_Z,            16'h0010, 16'h0000, 16'h0022, S_HALT, 1'b0));
        tbl.push_back(mk(F_UNC | F_LNK,         16'h0010, 16'h0000, 16'h0022, S_HALT, 1'b0));
        tbl.push_back(mk(F_BRR | F_RET,         16'h0000, 16'h0040, 16'h0022, S_HALT, 1'b0));
        tbl.push_back(mk(F_STL | F_HLT,         16'h0000, 16'h0000, 16'h0022, S_HALT, 1'b0));
        tbl.push_back(mk(0,                     16'h0000, 16'h0000, 16'h0022, S_HALT, 1'b0));
        tbl.push_back(mk(F_RES,                 16'h0000, 16'h0000, 16'h0022, S_RUN,  1'b1));
        tbl.push_back(mk(0,                     16'h0000, 16'h0000, 16'h0024, S_RUN,  1'b1));
        tbl.push_back(mk(F_HLT,                 16'h0000, 16'h0000, 16'h0026, S_HALT, 1'b0));
        tbl.push_back(mk(F_RST | F_BR | F_Z | F_BRR, 16'h0010, 16'h0040, 16'h0000, S_BOOT, 1'b0));
        tbl.push_back(mk(F_BRR | F_HLT,         16'h0000, 16'h0040, 16'h0000, S_RUN,  1'b1));
        tbl.push_back(mk(0,                     16'h0000, 16'h0000, 16'h0002, S_RUN,  1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].flags, tbl[i].se, tbl[i].rt);
            tick();
            chk_out($sformatf("vec%0d", i), tbl[i].epc, tbl[i].est, tbl[i].ev);
        end

        // Call / return sequence.
        drive(F_RST, 16'h0, 16'h0);          tick(); chk_out("cr.rst",  16'h0000, S_BOOT, 1'b0);
        drive(0, 16'h0, 16'h0);              tick(); chk_out("cr.boot", 16'h0000, S_RUN,  1'b1);
        drive(F_BRR, 16'h0, 16'h0100);       tick(); chk_out("cr.jmp",  16'h0100, S_RUN,  1'b1);
        drive(F_UNC | F_LNK, 16'h0080, 16'h0); tick(); chk_out("cr.bl1", 16'h0200, S_RUN, 1'b1);
        drive(F_UNC | F_LNK, 16'h0080, 16'h0); tick(); chk_out("cr.bl2", 16'h0300, S_RUN, 1'b1);
        drive(F_BRR | F_RET, 16'h0, 16'h0);  tick(); chk_out("cr.ret1", RAS_ON ? 16'h0202 : 16'h0000, S_RUN, 1'b1);
        drive(F_BRR | F_RET, 16'h0, 16'h0);  tick(); chk_out("cr.ret2", RAS_ON ? 16'h0102 : 16'h0000, S_RUN, 1'b1);
        drive(F_BRR | F_RET, 16'h0, 16'h0);  tick(); chk_out("cr.ret3", 16'h0000, S_RUN, 1'b1);

        // Reset while halted with a live stack entry leaves the stack empty.
        drive(F_UNC | F_LNK, 16'h0080, 16'h0); tick(); chk_out("rh.bl",  16'h0100, S_RUN, 1'b1);
        drive(F_HLT, 16'h0, 16'h0);          tick(); chk_out("rh.halt", 16'h0102, S_HALT, 1'b0);
        drive(F_RST | F_BR | F_Z, 16'h0010, 16'h0); tick(); chk_out("rh.rst", 16'h0000, S_BOOT, 1'b0);
        drive(0, 16'h0, 16'h0);              tick(); chk_out("rh.boot", 16'h0000, S_RUN, 1'b1);
        drive(F_BRR | F_RET, 16'h0, 16'h0051); tick(); chk_out("rh.ret", 16'h0050, S_RUN, 1'b1);

        // Randomized phase against the reference model.
        drive(F_RST, 16'h0, 16'h0);
        model_step();
        tick();
        chk_out("rnd.rst", 16'(m_pc), 2'(m_st), m_st == 1);
        for (int n = 0; n < 3000; n++) begin
            int f;
            logic [15:0] se;
            f = 0;
            if ($urandom_range(0, 63) == 0) f |= F_RST;
            if ($urandom_range(0, 2) == 0)  f |= F_BR;
            if ($urandom_range(0, 1) == 0)  f |= F_Z;
            if ($urandom_range(0, 3) == 0)  f |= F_UNC;
            if ($urandom_range(0, 1) == 0)  f |= F_LNK;
            if ($urandom_range(0, 5) == 0)  f |= F_BRR;
            if ($urandom_range(0, 1) == 0)  f |= F_RET;
            if ($urandom_range(0, 4) == 0)  f |= F_STL;
            if ($urandom_range(0, 15) == 0) f |= F_HLT;
            if ($urandom_range(0, 3) == 0)  f |= F_RES;
            if ($urandom_range(0, 1) == 0)
                se = 16'($urandom_range(0, 31)) - 16'd16;
            else
                se = 16'($urandom);
            drive(f, se, 16'($urandom));
            model_step();
            tick();
            chk_out("rnd", 16'(m_pc), 2'(m_st), m_st == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
